vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Raster timing generator for the VGA output path. Sits directly downstream of the pixel-clock divider: clocked by the divided pixel clock, held in reset by the divider's reset pulse. Produces horizontal and vertical sync, the visible-area flag, the current pixel coordinates and line/frame start strobes for the pixel source. Defaults give 640x480 @ 60 Hz with a 25 MHz pixel clock.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- clk  in  1  pixel clock, divided clock from the clock divider
- reset  in  1  synchronous, active-high; driven by the divider's reset output
- ce  in  1  pixel enable; counters advance only on edges with ce=1 (tie to 1 when clk is the true pixel clock)
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- video_on  out  1  1 while the current pixel is in the visible area
- pixel_x  out  10  current horizontal count (hcount)
- pixel_y  out  10  current vertical count (vcount)
- line_start  out  1  1 while hcount=0 (one pixel period per line)
- frame_start  out  1  1 while hcount=0 and vcount=0 (one pixel period per frame)

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). Both must be <= 1024; counters are 10-bit unsigned.
- State: hcount[9:0], vcount[9:0], running flag.
- On edge with reset=1: hcount=0, vcount=0, running=0. Reset wins over ce.
- On edge with reset=0, ce=1, running=0: running<=1; counters hold at 0.
- On edge with reset=0, ce=1, running=1: if hcount=H_TOTAL-1 then hcount<=0 and (vcount<=0 if vcount=V_TOTAL-1 else vcount+1); else hcount+1.
- On edge with ce=0: all state holds.
- Outputs are decoded from registered state (no extra pipeline), all gated by running:
  - video_on = running & hcount<H_VISIBLE & vcount<V_VISIBLE
  - hsync asserted (=SYNC_POL) when running & H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC; else ~SYNC_POL
  - vsync asserted when running & V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC; else ~SYNC_POL
  - line_start = running & hcount=0; frame_start = line_start & vcount=0
  - pixel_x = hcount, pixel_y = vcount
- vsync changes only at hcount=0 boundaries (line granularity); no half-line offset.
- Reset mid-frame: next edge returns to reset state regardless of position; a new frame begins after release.

## Timing
- Reset values (running=0): pixel_x=0, pixel_y=0, video_on=0, line_start=0, frame_start=0, hsync=vsync=~SYNC_POL (1 for defaults).
- First qualifying edge after reset release (ce=1) sets running; from that edge, outputs show pixel (0,0) with video_on=1, line_start=1, frame_start=1.
- One pixel = one ce-qualified clk edge. Line = 800 pixels, frame = 420000 pixels.
- Defaults: hsync low for hcount 656..751; vsync low for vcount 490..491; video_on for hcount 0..639 and vcount 0..479.
- Output change latency from counter update: 0 cycles (all outputs consistent with pixel_x/pixel_y in the same cycle).

## Test plan
- Reset held 5 cycles, then released, ce=1 -> during reset all outputs at reset values, hsync=vsync=1; one edge after release pixel_x=0, pixel_y=0, video_on=1, frame_start=1.
- Run one full line -> video_on high exactly 640 consecutive pixels, hsync low exactly for pixel_x 656..751 (96 pixels), line_start high once per 800 pixels.
- Run one full frame -> vsync low exactly for lines 490..491 (1600 pixels), frame_start period 420000 pixels, video_on never high for pixel_y>=480.
- Wrap: at pixel_x=799, pixel_y=524 -> next pixel (0,0) with frame_start=1; at pixel_x=799, pixel_y=10 -> next (0,11).
- ce toggling 1/0 on alternate clocks -> counts advance every other clk, hsync width 192 clk cycles, all outputs stable across ce=0 cycles.
- Reset asserted at pixel (700,300) with hsync low -> next edge returns all outputs to reset values; after release frame restarts at (0,0).

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// Signal bundle between the raster timing generator and the pixel source.
// The generator (master) receives the pixel enable and drives the timing outputs.
interface vga_sync_gen_if;
    logic       ce;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  ce,
        output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
    );

    modport slave (
        output ce,
        input  hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Raster timing generator: horizontal/vertical counters plus sync, visible-area
// and line/frame strobes decoded combinationally from the registered counters.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter logic        SYNC_POL  = 1'b0
) (
    input logic            clk,
    input logic            reset,
    vga_sync_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [9:0]  hcount;
    logic [9:0]  hcount_next;
    logic [9:0]  vcount;
    logic [9:0]  vcount_next;
    logic        running;
    logic [10:0] hx;
    logic [10:0] vx;
    logic        in_hsync;
    logic        in_vsync;

    // State and counter registers; reset wins over ce, ce=0 holds everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            hcount <= '0;
            vcount <= '0;
        end else if (vga.ce) begin
            state  <= state_next;
            hcount <= hcount_next;
            vcount <= vcount_next;
        end
    end

    // Next state: the first enabled edge after reset only starts the raster,
    // subsequent ones advance the pixel position with line/frame wrap.
    always_comb begin
        state_next  = state;
        hcount_next = hcount;
        vcount_next = vcount;
        if (state == ST_IDLE) begin
            state_next = ST_RUN;
        end else if (hcount == H_LAST) begin
            hcount_next = '0;
            vcount_next = (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
            hcount_next = hcount + 10'd1;
        end
    end

    // Output decode from the registered position, gated by running.
    always_comb begin
        running         = (state == ST_RUN);
        hx              = {1'b0, hcount};
        vx              = {1'b0, vcount};
        in_hsync        = running && (hx >= H_SYNC_BEG) && (hx < H_SYNC_END);
        in_vsync        = running && (vx >= V_SYNC_BEG) && (vx < V_SYNC_END);
        vga.hsync       = in_hsync ? SYNC_POL : ~SYNC_POL;
        vga.vsync       = in_vsync ? SYNC_POL : ~SYNC_POL;
        vga.video_on    = running && (hx < H_VIS_END) && (vx < V_VIS_END);
        vga.line_start  = running && (hcount == '0);
        vga.frame_start = running && (hcount == '0) && (vcount == '0);
        vga.pixel_x     = hcount;
        vga.pixel_y     = vcount;
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a small active-high
// instance share clk/reset/ce, each checked against a linear-pixel-index model.
module tb_vga_sync_gen;

    localparam int HT_A = 800;
    localparam int FRAME_A = 800 * 525;
    localparam int HT_B = 58;
    localparam int VT_B = 30;
    localparam int FRAME_B = HT_B * VT_B;

    logic clk = 1'b0;
    logic reset;
    logic ce;

    int n_checks = 0;
    int n_fail = 0;

    vga_sync_gen_if ia ();
    vga_sync_gen_if ib ();

    assign ia.ce = ce;
    assign ib.ce = ce;

    vga_sync_gen u_a (
        .clk   (clk),
        .reset (reset),
        .vga   (ia)
    );

    vga_sync_gen #(
        .H_VISIBLE (40),
        .H_FP      (4),
        .H_SYNC    (8),
        .H_BP      (6),
        .V_VISIBLE (20),
        .V_FP      (3),
        .V_SYNC    (2),
        .V_BP      (5),
        .SYNC_POL  (1'b1)
    ) u_b (
        .clk   (clk),
        .reset (reset),
        .vga   (ib)
    );

    always #5 clk = ~clk;

    // Reference: pixel position as a linear index into the frame.
    int p_a = 0;
    int p_b = 0;
    bit run_a = 1'b0;
    bit run_b = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            run_a <= 1'b0; p_a <= 0;
            run_b <= 1'b0; p_b <= 0;
        end else if (ce) begin
            if (run_a) p_a <= (p_a + 1) % FRAME_A; else run_a <= 1'b1;
            if (run_b) p_b <= (p_b + 1) % FRAME_B; else run_b <= 1'b1;
        end
    end

    // Packed as {hsync, vsync, video_on, line_start, frame_start, x, y}.
    function automatic logic [24:0] model_out(input int p, input bit run,
            input int hv, input int hf, input int hs, input int hb,
            input int vv, input int vf, input int vs, input bit pol);
        int x, y, ht;
        bit vid, hon, von, ls, fs;
        ht  = hv + hf + hs + hb;
        x   = p % ht;
        y   = p / ht;
        vid = run && x < hv && y < vv;
        hon = run && x >= hv + hf && x < hv + hf + hs;
        von = run && y >= vv + vf && y < vv + vf + vs;
        ls  = run && x == 0;
        fs  = ls && y == 0;
        return {hon ? pol : ~pol, von ? pol : ~pol, vid, ls, fs, 10'(x), 10'(y)};
    endfunction

    logic [24:0] exp_a, exp_b, obs_a, obs_b;
    assign exp_a = model_out(p_a, run_a, 640, 16, 96, 48, 480, 10, 2, 1'b0);
    assign exp_b = model_out(p_b, run_b, 40, 4, 8, 6, 20, 3, 2, 1'b1);
    assign obs_a = {ia.hsync, ia.vsync, ia.video_on, ia.line_start, ia.frame_start, ia.pixel_x, ia.pixel_y};
    assign obs_b = {ib.hsync, ib.vsync, ib.video_on, ib.line_start, ib.frame_start, ib.pixel_x, ib.pixel_y};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (obs_a !== {2'b11, 23'd0}) begin
                n_fail++; $display("FAIL reset_a got %h want %h", obs_a, {2'b11, 23'd0});
            end
            n_checks++;
            if (obs_b !== 25'd0) begin
                n_fail++; $display("FAIL reset_b got %h want %h", obs_b, 25'd0);
            end
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (obs_a !== {2'b11, 3'b111, 20'd0}) begin
            n_fail++; $display("FAIL first_pixel_a got %h want %h", obs_a, {2'b11, 3'b111, 20'd0});
        end
        n_checks++;
        if (obs_b !== {2'b00, 3'b111, 20'd0}) begin
            n_fail++; $display("FAIL first_pixel_b got %h want %h", obs_b, {2'b00, 3'b111, 20'd0});
        end
    endtask

    task automatic test_line();
        int vid_cnt = 0, vid_first = -1, vid_last = -1;
        int hs_cnt = 0, hs_first = -1, hs_last = -1, ls_cnt = 0;
        for (int i = 0; i < HT_A; i++) begin
            n_checks++;
            if (obs_a !== exp_a) begin
                n_fail++; $display("FAIL line_model got %h want %h", obs_a, exp_a);
            end
            if (ia.video_on) begin
                vid_cnt++; vid_last = int'(ia.pixel_x);
                if (vid_first < 0) vid_first = int'(ia.pixel_x);
            end
            if (!ia.hsync) begin
                hs_cnt++; hs_last = int'(ia.pixel_x);
                if (hs_first < 0) hs_first = int'(ia.pixel_x);
            end
            if (ia.line_start) ls_cnt++;
            tick();
        end
        n_checks++;
        if (vid_cnt != 640 || vid_first != 0 || vid_last != 639) begin
            n_fail++; $display("FAIL line_video got cnt=%0d %0d..%0d want 640 0..639", vid_cnt, vid_first, vid_last);
        end
        n_checks++;
        if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
            n_fail++; $display("FAIL line_hsync got cnt=%0d %0d..%0d want 96 656..751", hs_cnt, hs_first, hs_last);
        end
        n_checks++;
        if (ls_cnt != 1) begin
            n_fail++; $display("FAIL line_start_count got %0d want 1", ls_cnt);
        end
    endtask

    task automatic test_frame();
        bit found = 1'b0;
        int vs_cnt = 0, vs_first = -1, vs_last = -1, bad_vid = 0, fs_cnt = 0;
        for (int i = 0; i < 2 * FRAME_B && !found; i++) begin
            if (ib.frame_start) found = 1'b1; else tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL frame_align got timeout want frame_start");
        end
        for (int i = 0; i < FRAME_B; i++) begin
            n_checks++;
            if (obs_b !== exp_b) begin
                n_fail++; $display("FAIL frame_model got %h want %h", obs_b, exp_b);
            end
            if (ib.vsync) begin
                vs_cnt++; vs_last = int'(ib.pixel_y);
                if (vs_first < 0) vs_first = int'(ib.pixel_y);
            end
            if (ib.video_on && ib.pixel_y >= 10'd20) bad_vid++;
            if (ib.frame_start) fs_cnt++;
            tick();
        end
        n_checks++;
        if (vs_cnt != 2 * HT_B || vs_first != 23 || vs_last != 24) begin
            n_fail++; $display("FAIL frame_vsync got cnt=%0d lines %0d..%0d want %0d 23..24", vs_cnt, vs_first, vs_last, 2 * HT_B);
        end
        n_checks++;
        if (bad_vid != 0) begin
            n_fail++; $display("FAIL frame_video_blank got %0d want 0", bad_vid);
        end
        n_checks++;
        if (fs_cnt != 1 || ib.frame_start !== 1'b1) begin
            n_fail++; $display("FAIL frame_period got cnt=%0d next=%b want 1 1", fs_cnt, ib.frame_start);
        end
    endtask

    task automatic test_wrap();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_B && !found; i++) begin
            if (ib.pixel_x == 10'(HT_B - 1) && ib.pixel_y == 10'(VT_B - 1)) found = 1'b1; else tick();
        end
        tick();
        n_checks++;
        if (!found || obs_b !== {2'b00, 3'b111, 20'd0}) begin
            n_fail++; $display("FAIL wrap_frame_b got %h found=%b want %h", obs_b, found, {2'b00, 3'b111, 20'd0});
        end
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_B && !found; i++) begin
            if (ib.pixel_x == 10'(HT_B - 1) && ib.pixel_y == 10'd10) found = 1'b1; else tick();
        end
        tick();
        n_checks++;
        if (!found || obs_b !== {2'b00, 3'b110, 10'd0, 10'd11}) begin
            n_fail++; $display("FAIL wrap_line_b got %h found=%b want %h", obs_b, found, {2'b00, 3'b110, 10'd0, 10'd11});
        end
        found = 1'b0;
        for (int i = 0; i < 12000 && !found; i++) begin
            if (ia.pixel_x == 10'd799 && ia.pixel_y == 10'd10) found = 1'b1; else tick();
        end
        tick();
        n_checks++;
        if (!found || obs_a !== {2'b11, 3'b110, 10'd0, 10'd11}) begin
            n_fail++; $display("FAIL wrap_line_a got %h found=%b want %h", obs_a, found, {2'b11, 3'b110, 10'd0, 10'd11});
        end
    endtask

    task automatic test_ce_toggle();
        logic [24:0] prev;
        int low_len = 0, width = -1;
        bit seen_high = 1'b0;
        for (int i = 0; i < 2400; i++) begin
            prev = obs_a;
            ce = (i % 2 == 0);
            tick();
            n_checks++;
            if (obs_a !== exp_a) begin
                n_fail++; $display("FAIL ce_model got %h want %h", obs_a, exp_a);
            end
            if (!ce) begin
                n_checks++;
                if (obs_a !== prev) begin
                    n_fail++; $display("FAIL ce_hold got %h want %h", obs_a, prev);
                end
            end
            if (ia.hsync) begin
                if (seen_high && low_len > 0 && width < 0) width = low_len;
                seen_high = 1'b1;
                low_len = 0;
            end else if (seen_high) begin
                low_len++;
            end
        end
        ce = 1'b1;
        n_checks++;
        if (width != 192) begin
            n_fail++; $display("FAIL ce_hsync_width got %0d want 192", width);
        end
    endtask

    task automatic test_random_ce();
        for (int i = 0; i < 3000; i++) begin
            ce = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 499) == 0);
            tick();
            n_checks++;
            if (obs_a !== exp_a) begin
                n_fail++; $display("FAIL rand_a got %h want %h", obs_a, exp_a);
            end
            n_checks++;
            if (obs_b !== exp_b) begin
                n_fail++; $display("FAIL rand_b got %h want %h", obs_b, exp_b);
            end
        end
        reset = 1'b0;
        ce = 1'b1;
    endtask

    task automatic test_mid_reset();
        bit found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (ia.pixel_x == 10'd700) found = 1'b1; else tick();
        end
        n_checks++;
        if (!found || ia.hsync !== 1'b0) begin
            n_fail++; $display("FAIL mid_pos got x=%0d hsync=%b want 700 0", ia.pixel_x, ia.hsync);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (obs_a !== {2'b11, 23'd0}) begin
            n_fail++; $display("FAIL mid_reset_a got %h want %h", obs_a, {2'b11, 23'd0});
        end
        n_checks++;
        if (obs_b !== 25'd0) begin
            n_fail++; $display("FAIL mid_reset_b got %h want %h", obs_b, 25'd0);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (obs_a !== {2'b11, 3'b111, 20'd0}) begin
            n_fail++; $display("FAIL mid_restart_a got %h want %h", obs_a, {2'b11, 3'b111, 20'd0});
        end
        tick();
        n_checks++;
        if (obs_a !== exp_a || ia.pixel_x !== 10'd1) begin
            n_fail++; $display("FAIL mid_advance_a got %h want %h", obs_a, exp_a);
        end
    endtask

    initial begin
        reset = 1'b1;
        ce = 1'b1;
        test_reset();
        test_line();
        test_frame();
        test_wrap();
        test_ce_toggle();
        test_random_ce();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
